// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: pops a source FIFO, absorbs its read latency in a skid buffer, pushes to a destination FIFO
module fifo_drain_ctrl #(
    parameter int DATA_W     = 10,
    parameter int READ_LAT   = 1,
    parameter int SKID_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              enable,
    input  logic              src_empty,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_pop,
    input  logic              dst_almost_full,
    output logic              dst_push,
    output logic [DATA_W-1:0] dst_data,
    output logic              idle,
    output logic [7:0]        fwd_count
);
    localparam int OCC_W = $clog2(SKID_DEPTH + 1);
    localparam int CNT_W = $clog2(SKID_DEPTH + READ_LAT + 1) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STALL, S_DRAIN} state_t;

    state_t              r_state, w_state_nxt;
    logic [READ_LAT-1:0] r_pipe;
    logic [OCC_W-1:0]    r_occ, w_occ_nxt, w_wr_pos;
    logic [DATA_W-1:0]   r_skid     [SKID_DEPTH];
    logic [DATA_W-1:0]   w_skid_nxt [SKID_DEPTH];
    logic [7:0]          r_fwd_count;
    logic [CNT_W-1:0]    w_inflight, w_total;
    logic                w_capture, w_quiet;

    // count pops whose data has not yet come back from the source
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < READ_LAT; i++) w_inflight = w_inflight + CNT_W'(r_pipe[i]);
    end

    // zero is the source FIFO's "no data" value, so it is never buffered
    assign w_capture = r_pipe[READ_LAT-1] && (src_data != '0);
    assign w_total   = CNT_W'(r_occ) + w_inflight;
    assign w_quiet   = (r_occ == '0) && (w_inflight == '0);
    assign src_pop   = enable && !src_empty && (w_total < CNT_W'(SKID_DEPTH))
                       && (r_state == S_RUN || r_state == S_STALL);
    assign dst_push  = (r_occ != '0) && !dst_almost_full;
    assign dst_data  = (r_occ != '0) ? r_skid[0] : '0;
    assign idle      = (r_state == S_IDLE) && w_quiet;
    assign fwd_count = r_fwd_count;
    assign w_wr_pos  = r_occ - OCC_W'(dst_push);
    assign w_occ_nxt = r_occ + OCC_W'(w_capture) - OCC_W'(dst_push);

    // skid is a shift queue: head at index 0, a push shifts down, a capture lands behind the last live entry
    always_comb begin
        for (int i = 0; i < SKID_DEPTH; i++) begin
            w_skid_nxt[i] = dst_push ? ((i == SKID_DEPTH - 1) ? '0 : r_skid[(i + 1) % SKID_DEPTH]) : r_skid[i];
            if (w_capture && w_wr_pos == OCC_W'(i)) w_skid_nxt[i] = src_data;
        end
    end

    // next-state: disable wins over backpressure in RUN/STALL
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = (enable && !src_empty) ? S_RUN : S_IDLE;
            S_RUN:   w_state_nxt = !enable ? S_DRAIN : dst_almost_full ? S_STALL
                                 : (src_empty && w_quiet) ? S_IDLE : S_RUN;
            S_STALL: w_state_nxt = !enable ? S_DRAIN : !dst_almost_full ? S_RUN : S_STALL;
            S_DRAIN: w_state_nxt = w_quiet ? S_IDLE : S_DRAIN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // state, in-flight pipe, skid and forward counter registers
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state     <= S_IDLE;
            r_pipe      <= '0;
            r_occ       <= '0;
            r_fwd_count <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) r_skid[i] <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pipe      <= (r_pipe << 1) | READ_LAT'(src_pop);
            r_occ       <= w_occ_nxt;
            r_fwd_count <= r_fwd_count + 8'(dst_push);
            for (int i = 0; i < SKID_DEPTH; i++) r_skid[i] <= w_skid_nxt[i];
        end
    end

    // a capture into a full skid would silently lose a word
    always @(posedge clk) begin
        if (reset_L) assert (!(w_capture && !dst_push && r_occ == OCC_W'(SKID_DEPTH))) else $error("skid overflow");
    end
endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// tb_fifo_drain_ctrl: directed scenarios for the FIFO drain controller
module tb_fifo_drain_ctrl;
    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic       enable = 1'b0;
    logic       dst_almost_full = 1'b0;
    logic       src_empty, src_pop, dst_push, idle;
    logic [9:0] src_data = '0;
    logic [9:0] dst_data;
    logic [7:0] fwd_count;

    int checks = 0;
    int failures = 0;
    logic [9:0] src_arr [1024];
    int src_n = 0;
    int src_rd = 0;
    logic [9:0] got [1024];
    int gn = 0;
    int npop = 0;

    fifo_drain_ctrl #(.DATA_W(10), .READ_LAT(1), .SKID_DEPTH(2)) dut (
        .clk(clk), .reset_L(reset_L), .enable(enable), .src_empty(src_empty),
        .src_data(src_data), .src_pop(src_pop), .dst_almost_full(dst_almost_full),
        .dst_push(dst_push), .dst_data(dst_data), .idle(idle), .fwd_count(fwd_count)
    );

    always #5 clk = ~clk;

    assign src_empty = (src_rd >= src_n);

    // source FIFO model: popped word appears on src_data one cycle later, zero otherwise
    always @(posedge clk) begin
        if (src_pop && src_rd < src_n) begin
            src_data <= src_arr[src_rd];
            src_rd   <= src_rd + 1;
        end else src_data <= '0;
    end

    // destination capture and protocol watch
    always @(negedge clk) begin
        if (dst_push) begin
            got[gn] = dst_data;
            gn++;
        end
        if (src_pop) npop++;
        if (src_pop && src_empty) begin
            failures++;
            $display("FAIL pop_on_empty: src_pop=1 while src_empty=1 at %0t", $time);
        end
        if (dst_push && dst_almost_full) begin
            failures++;
            $display("FAIL push_on_full: dst_push=1 while dst_almost_full=1 at %0t", $time);
        end
    end

    task automatic load(input logic [9:0] w);
        src_arr[src_n] = w;
        src_n++;
    endtask

    task automatic do_reset;
        reset_L = 1'b0;
        enable = 1'b0;
        dst_almost_full = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_L = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_L = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (src_pop !== 1'b0) begin failures++; $display("FAIL rst_src_pop: got %b want 0", src_pop); end
        checks++; if (dst_push !== 1'b0) begin failures++; $display("FAIL rst_dst_push: got %b want 0", dst_push); end
        checks++; if (dst_data !== 10'h000) begin failures++; $display("FAIL rst_dst_data: got %h want 000", dst_data); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL rst_idle: got %b want 1", idle); end
        checks++; if (fwd_count !== 8'd0) begin failures++; $display("FAIL rst_fwd_count: got %0d want 0", fwd_count); end
        reset_L = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL rst_idle_after: got %b want 1", idle); end
    endtask

    task automatic test_basic;
        int base, p0, c;
        do_reset;
        base = gn; p0 = npop; c = 0;
        for (int i = 1; i <= 5; i++) load(10'(i));
        enable = 1'b1;
        while (!(gn - base >= 5 && idle && src_empty) && c < 200) begin @(negedge clk); #1; c++; end
        checks++; if (c >= 200) begin failures++; $display("FAIL basic_timeout: delivered %0d want 5", gn - base); end
        checks++; if (gn - base !== 5) begin failures++; $display("FAIL basic_count: got %0d want 5", gn - base); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got[base+i] !== 10'(i + 1)) begin failures++; $display("FAIL basic_word%0d: got %h want %h", i, got[base+i], 10'(i + 1)); end
        end
        checks++; if (fwd_count !== 8'd5) begin failures++; $display("FAIL basic_fwd_count: got %0d want 5", fwd_count); end
        checks++; if (npop - p0 !== 5) begin failures++; $display("FAIL basic_pops: got %0d want 5", npop - p0); end
        enable = 1'b0;
    endtask

    task automatic test_reset_mid;
        int base, p0, c;
        base = gn; p0 = npop; c = 0;
        load(10'h101); load(10'h102); load(10'h103);
        @(posedge clk);
        #1 enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (dst_push !== 1'b1 || dst_data !== 10'h101) begin failures++; $display("FAIL mid_pre_push: got %b/%h want 1/101", dst_push, dst_data); end
        #2 reset_L = 1'b0;
        enable = 1'b0;
        #1;
        checks++; if (src_pop !== 1'b0) begin failures++; $display("FAIL mid_src_pop: got %b want 0", src_pop); end
        checks++; if (dst_push !== 1'b0) begin failures++; $display("FAIL mid_dst_push: got %b want 0", dst_push); end
        checks++; if (dst_data !== 10'h000) begin failures++; $display("FAIL mid_dst_data: got %h want 000", dst_data); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL mid_idle: got %b want 1", idle); end
        checks++; if (fwd_count !== 8'd0) begin failures++; $display("FAIL mid_fwd_count: got %0d want 0", fwd_count); end
        checks++; if (npop - p0 !== 2) begin failures++; $display("FAIL mid_pops: got %0d want 2", npop - p0); end
        @(posedge clk);
        #3 reset_L = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        checks++; if (gn - base !== 0) begin failures++; $display("FAIL mid_no_push: got %0d pushes want 0", gn - base); end
        @(posedge clk);
        #1 enable = 1'b1;
        while (!(gn - base >= 1 && idle && src_empty) && c < 100) begin @(negedge clk); #1; c++; end
        checks++; if (c >= 100) begin failures++; $display("FAIL mid_timeout: delivered %0d want 1", gn - base); end
        checks++; if (gn - base !== 1 || got[base] !== 10'h103) begin failures++; $display("FAIL mid_word: got %0d words first %h want 1 word 103", gn - base, got[base]); end
        checks++; if (fwd_count !== 8'd1) begin failures++; $display("FAIL mid_fwd_after: got %0d want 1", fwd_count); end
        enable = 1'b0;
    endtask

    task automatic test_backpressure;
        int base, p0, c;
        do_reset;
        base = gn; p0 = npop; c = 0;
        for (int i = 1; i <= 8; i++) load(10'h0C0 + 10'(i));
        enable = 1'b1;
        repeat (2) @(posedge clk);
        #1 dst_almost_full = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++; if (dst_push !== 1'b0) begin failures++; $display("FAIL bp_stall_push%0d: got %b want 0", k, dst_push); end
        end
        checks++; if (src_pop !== 1'b0) begin failures++; $display("FAIL bp_stall_pop: got %b want 0", src_pop); end
        checks++; if (npop - p0 !== 2) begin failures++; $display("FAIL bp_stall_pops: got %0d want 2", npop - p0); end
        @(posedge clk);
        #1 dst_almost_full = 1'b0;
        while (!(gn - base >= 8 && idle && src_empty) && c < 200) begin @(negedge clk); #1; c++; end
        checks++; if (c >= 200) begin failures++; $display("FAIL bp_timeout: delivered %0d want 8", gn - base); end
        checks++; if (gn - base !== 8) begin failures++; $display("FAIL bp_count: got %0d want 8", gn - base); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got[base+i] !== 10'h0C1 + 10'(i)) begin failures++; $display("FAIL bp_word%0d: got %h want %h", i, got[base+i], 10'h0C1 + 10'(i)); end
        end
        checks++; if (fwd_count !== 8'd8) begin failures++; $display("FAIL bp_fwd_count: got %0d want 8", fwd_count); end
        enable = 1'b0;
    endtask

    task automatic test_zero;
        int base, p0, c;
        do_reset;
        base = gn; p0 = npop; c = 0;
        load(10'h00A); load(10'h000); load(10'h00B);
        enable = 1'b1;
        while (!(gn - base >= 2 && idle && src_empty) && c < 100) begin @(negedge clk); #1; c++; end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (c >= 100) begin failures++; $display("FAIL zero_timeout: delivered %0d want 2", gn - base); end
        checks++; if (gn - base !== 2) begin failures++; $display("FAIL zero_count: got %0d want 2", gn - base); end
        checks++; if (got[base] !== 10'h00A) begin failures++; $display("FAIL zero_word0: got %h want 00a", got[base]); end
        checks++; if (got[base+1] !== 10'h00B) begin failures++; $display("FAIL zero_word1: got %h want 00b", got[base+1]); end
        checks++; if (fwd_count !== 8'd2) begin failures++; $display("FAIL zero_fwd_count: got %0d want 2", fwd_count); end
        checks++; if (npop - p0 !== 3) begin failures++; $display("FAIL zero_pops: got %0d want 3", npop - p0); end
        enable = 1'b0;
    endtask

    task automatic test_wrap;
        int base, c, bad;
        do_reset;
        base = gn; c = 0; bad = 0;
        for (int i = 0; i < 257; i++) load(10'(i + 1));
        enable = 1'b1;
        while (!(gn - base >= 257 && idle && src_empty) && c < 2000) begin @(negedge clk); #1; c++; end
        checks++; if (c >= 2000) begin failures++; $display("FAIL wrap_timeout: delivered %0d want 257", gn - base); end
        checks++; if (gn - base !== 257) begin failures++; $display("FAIL wrap_count: got %0d want 257", gn - base); end
        for (int i = 0; i < 257; i++) if (got[base+i] !== 10'(i + 1)) bad++;
        checks++; if (bad !== 0) begin failures++; $display("FAIL wrap_order: got %0d misordered words want 0", bad); end
        checks++; if (fwd_count !== 8'd1) begin failures++; $display("FAIL wrap_fwd_count: got %0d want 1", fwd_count); end
        enable = 1'b0;
    endtask

    task automatic test_enable_drop;
        int base, p0, c;
        do_reset;
        base = gn; p0 = npop; c = 0;
        for (int i = 1; i <= 4; i++) load(10'h0E0 + 10'(i));
        enable = 1'b1;
        repeat (3) @(posedge clk);
        #1 enable = 1'b0;
        checks++; if (src_pop !== 1'b0) begin failures++; $display("FAIL drop_src_pop: got %b want 0", src_pop); end
        while (!(gn - base >= 2 && idle) && c < 100) begin @(negedge clk); #1; c++; end
        repeat (5) @(negedge clk);
        #1;
        checks++; if (c >= 100) begin failures++; $display("FAIL drop_timeout: delivered %0d want 2", gn - base); end
        checks++; if (npop - p0 !== 2) begin failures++; $display("FAIL drop_pops: got %0d want 2", npop - p0); end
        checks++; if (gn - base !== 2) begin failures++; $display("FAIL drop_count: got %0d want 2", gn - base); end
        checks++; if (got[base] !== 10'h0E1) begin failures++; $display("FAIL drop_word0: got %h want 0e1", got[base]); end
        checks++; if (got[base+1] !== 10'h0E2) begin failures++; $display("FAIL drop_word1: got %h want 0e2", got[base+1]); end
        checks++; if (src_n - src_rd !== 2) begin failures++; $display("FAIL drop_src_left: got %0d want 2", src_n - src_rd); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL drop_idle: got %b want 1", idle); end
        checks++; if (fwd_count !== 8'd2) begin failures++; $display("FAIL drop_fwd_count: got %0d want 2", fwd_count); end
    endtask

    // overall time bound
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_basic;
        test_reset_mid;
        test_backpressure;
        test_zero;
        test_wrap;
        test_enable_drop;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
